// File: rtl/tone_synth.sv
// tone_synth: frames 32-bit SPI words from sck/q, latches keys/octave, mixes 13 square voices into wave.
// Keys update 3 cycles after the 32nd sck edge pulse, wave lags voice levels by 1 cycle; no backpressure.
module tone_synth #(
    parameter int CLK_HZ  = 40_000_000,
    parameter int TIMEOUT = 4000,
    parameter int AMP     = 19
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sck,
    input  logic [31:0] q,
    output logic [7:0]  wave,
    output logic        frame_err
);
    localparam int         NV   = 13;
    localparam int         IW   = $clog2(TIMEOUT + 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [1:0] {IDLE, WAIT1, WAIT2, CHECK} state_t;

    // Equal-tempered pitches in mHz; the extra precision makes C4 round to its tuned value.
    function automatic logic [16:0] half_of(input int k);
        logic [63:0] f_mhz;
        case (k)
            0:       f_mhz = 64'd261626;
            1:       f_mhz = 64'd277183;
            2:       f_mhz = 64'd293665;
            3:       f_mhz = 64'd311127;
            4:       f_mhz = 64'd329628;
            5:       f_mhz = 64'd349228;
            6:       f_mhz = 64'd369994;
            7:       f_mhz = 64'd391995;
            8:       f_mhz = 64'd415305;
            9:       f_mhz = 64'd440000;
            10:      f_mhz = 64'd466164;
            11:      f_mhz = 64'd493883;
            default: f_mhz = 64'd523251;
        endcase
        return 17'((64'(CLK_HZ) * 64'd1000 + f_mhz) / (64'd2 * f_mhz));
    endfunction

    logic          sck_s1_q, sck_s1_d;
    logic          sck_s2_q, sck_s2_d;
    logic          sck_s3_q, sck_s3_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    state_t        state_q, state_d;
    logic [12:0]   keys_q, keys_d;
    logic [1:0]    oct_q, oct_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    wave_q, wave_d;
    logic          sck_rise;
    logic          frame_done;
    logic [NV-1:0] lvl_vec;
    logic [3:0]    n_high;
    logic          q_unused;

    assign q_unused   = ^q[23:15];
    assign sck_rise   = sck_s2_q & ~sck_s3_q;
    assign frame_done = sck_rise && (bit_cnt_q == 5'd31);

    always_comb begin
        sck_s1_d   = sck;
        sck_s2_d   = sck_s1_q;
        sck_s3_d   = sck_s2_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        if (sck_rise) begin
            bit_cnt_d  = bit_cnt_q + 5'd1;
            idle_cnt_d = '0;
        end else if (idle_cnt_q == IW'(TIMEOUT)) begin
            bit_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
        end
    end

    // The two wait states give q time to settle after the last sck edge before sampling.
    always_comb begin
        state_d     = state_q;
        keys_d      = keys_q;
        oct_d       = oct_q;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE:  if (frame_done) state_d = WAIT1;
            WAIT1: state_d = WAIT2;
            WAIT2: state_d = CHECK;
            CHECK: begin
                state_d = IDLE;
                if (q[31:24] == SYNC) begin
                    keys_d = q[12:0];
                    oct_d  = q[14:13];
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Voices look at the next key/octave values so releases and octave wraps land in the CHECK cycle.
    for (genvar k = 0; k < NV; k++) begin : g_voice
        localparam logic [16:0] HALF = half_of(k);
        logic [16:0] cnt_q, cnt_d;
        logic [16:0] lim;
        logic        lvl_q, lvl_d;

        always_comb begin
            lim   = HALF >> oct_d;
            cnt_d = cnt_q;
            lvl_d = lvl_q;
            if (!keys_d[k]) begin
                cnt_d = '0;
                lvl_d = 1'b0;
            end else if (cnt_q >= lim - 17'd1) begin
                cnt_d = '0;
                lvl_d = ~lvl_q;
            end else begin
                cnt_d = cnt_q + 17'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign lvl_vec[k] = lvl_q;
    end

    always_comb begin
        n_high = '0;
        for (int i = 0; i < NV; i++) begin
            n_high = n_high + 4'(lvl_vec[i]);
        end
        wave_d = 8'(AMP * int'(n_high));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_s1_q    <= 1'b0;
            sck_s2_q    <= 1'b0;
            sck_s3_q    <= 1'b0;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            state_q     <= IDLE;
            keys_q      <= '0;
            oct_q       <= '0;
            frame_err_q <= 1'b0;
            wave_q      <= '0;
        end else begin
            sck_s1_q    <= sck_s1_d;
            sck_s2_q    <= sck_s2_d;
            sck_s3_q    <= sck_s3_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            state_q     <= state_d;
            keys_q      <= keys_d;
            oct_q       <= oct_d;
            frame_err_q <= frame_err_d;
            wave_q      <= wave_d;
        end
    end

    assign wave      = wave_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tone_synth.sv
// Scoreboard bench for tone_synth: expectations are queued as frames are sent and popped as wave/frame_err respond.
module tb_tone_synth;
    localparam int CLK_HZ  = 2_000_000;
    localparam int TIMEOUT = 4000;
    localparam int AMP     = 19;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck     = 1'b0;
    logic [31:0] q       = '0;
    logic [7:0]  wave;
    logic        frame_err;

    tone_synth #(.CLK_HZ(CLK_HZ), .TIMEOUT(TIMEOUT), .AMP(AMP)) dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .q(q), .wave(wave), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    half_tb [13];
    string sb_tag [$];
    int    sb_val [$];

    function automatic real pitch(input int k);
        case (k)
            0: return 261.626;   1: return 277.183;   2: return 293.665;
            3: return 311.127;   4: return 329.628;   5: return 349.228;
            6: return 369.994;   7: return 391.995;   8: return 415.305;
            9: return 440.0;    10: return 466.164;  11: return 493.883;
            default: return 523.251;
        endcase
    endfunction

    // Closed-form voice levels: a voice enabled in CHECK cycle s toggles every lim cycles, wave lags by one.
    function automatic int model_wave(input int t, input int s, input logic [12:0] keys, input int oct);
        int n = 0;
        for (int k = 0; k < 13; k++) begin
            if (keys[k] && (t - 1 - s) >= 0 && (((t - 1 - s) / (half_tb[k] >> oct)) % 2) == 1) n++;
        end
        return AMP * n;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        sb_tag.push_back(tag);
        sb_val.push_back(val);
    endtask

    task automatic sb_pop(input int obs);
        if (sb_val.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: observed %0d with no expectation queued", obs);
        end else begin
            chk(sb_tag.pop_front(), obs, sb_val.pop_front());
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_change(input int budget, output int t);
        logic [7:0] prev;
        prev = wave;
        t    = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (wave !== prev) begin
                t = cyc;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wave_change_timeout: wave held %0d for %0d cycles", wave, budget);
    endtask

    // p returns the cycle of the 32nd sck rise; the task ends 4 cycles later with sck low.
    task automatic send_frame(input logic [31:0] w, output int p);
        p = 0;
        tick(8);
        q = w;
        for (int i = 0; i < 32; i++) begin
            sck = 1'b1;
            p   = cyc;
            tick(4);
            sck = 1'b0;
            if (i != 31) tick(4);
        end
    endtask

    initial begin
        int p, t, t0, lim, bad, first, fv, cnt, tf;
        for (int k = 0; k < 13; k++) half_tb[k] = $rtoi(CLK_HZ / (2.0 * pitch(k)) + 0.5);

        // Reset with sck activity that must not be counted.
        reset_n = 1'b0;
        q       = 32'hA5000200;
        tick(1); sck = 1'b1;
        tick(1); sck = 1'b0;
        tick(1); sck = 1'b1;
        chk("rst_wave", int'(wave), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        tick(1); sck = 1'b0; reset_n = 1'b1;

        // Single key A4, octave 0.
        lim = half_tb[9];
        send_frame(32'hA5000200, p);
        sb_push("a4_first_rise_t", p + 6 + lim);
        sb_push("a4_first_level", AMP);
        sb_push("a4_half_hi", lim);
        sb_push("a4_half_lo", lim);
        wait_change(lim + 50, t); sb_pop(t); sb_pop(int'(wave));
        t0 = t; wait_change(lim + 50, t); sb_pop(t - t0);
        t0 = t; wait_change(lim + 50, t); sb_pop(t - t0);

        // Octave 1, then octave 3 mid-phase forces an immediate wrap.
        send_frame(32'hA5002200, p);
        lim = half_tb[9] >> 1;
        sb_push("oct1_half", lim);
        wait_change(half_tb[9] + 50, t0); wait_change(lim + 50, t); sb_pop(t - t0);
        tick(600);
        send_frame(32'hA5006200, p);
        lim = half_tb[9] >> 3;
        sb_push("oct3_wrap_t", p + 7);
        sb_push("oct3_half", lim);
        wait_change(100, t); sb_pop(t);
        t0 = t; wait_change(lim + 50, t); sb_pop(t - t0);

        // Silence, then a full chord checked cycle by cycle against the closed-form model.
        send_frame(32'hA5000000, p);
        tick(10);
        chk("silence_wave", int'(wave), 0);
        send_frame(32'hA5001FFF, p);
        sb_push("chord_first_step_t", p + 6 + half_tb[12]);
        sb_push("chord_first_step_val", AMP);
        sb_push("chord_model_bad", 0);
        first = -1; fv = 0; bad = 0;
        for (int i = 0; i < 2 * half_tb[0] + 50; i++) begin
            if (first < 0 && wave != 0) begin
                first = cyc;
                fv    = int'(wave);
            end
            if (int'(wave) != model_wave(cyc, p + 5, 13'h1FFF, 0)) bad++;
            tick(1);
        end
        sb_pop(first); sb_pop(fv); sb_pop(bad);

        // Bad sync byte: one-cycle frame_err, A4 keeps its phase.
        lim = half_tb[9];
        send_frame(32'hA5000200, p);
        tick(10);
        wait_change(lim + 50, t0);
        send_frame(32'h5A000200, p);
        sb_push("bad_ferr_t", p + 6);
        sb_push("bad_ferr_width", 1);
        sb_push("bad_phase_cont", lim);
        cnt = 0; tf = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (frame_err === 1'b1) begin
                cnt++;
                if (tf < 0) tf = cyc;
            end
        end
        sb_pop(tf); sb_pop(cnt);
        wait_change(lim + 50, t); sb_pop(t - t0);

        // Release while the voice is high: wave drops right after CHECK.
        if (wave == 0) wait_change(lim + 50, t);
        send_frame(32'hA5000000, p);
        sb_push("off_hold_p6", AMP);
        sb_push("off_drop_t", p + 7);
        tick(2); sb_pop(int'(wave));
        wait_change(20, t); sb_pop(t);

        // Partial frame, idle past TIMEOUT, then a clean frame must frame correctly.
        tick(8);
        q = 32'h00000000;
        for (int i = 0; i < 20; i++) begin
            sck = 1'b1; tick(4);
            sck = 1'b0; tick(4);
        end
        tick(TIMEOUT + 1);
        send_frame(32'hA5000001, p);
        lim = half_tb[0];
        sb_push("resync_first_rise_t", p + 6 + lim);
        sb_push("resync_half", lim);
        wait_change(lim + 50, t); sb_pop(t);
        t0 = t; wait_change(lim + 50, t); sb_pop(t - t0);

        chk("sb_drained", sb_val.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tone_synth.md
# tone_synth

Polyphonic square-wave tone generator for the digital keyboard. Sits directly downstream of `spi_slave_receive_only`: it watches the raw `sck` line, frames 32-bit words out of the shift register's `q`, and latches a validated key/octave word. It runs one divider per key and mixes the active voices into the 8-bit unsigned `wave` sample for the DAC.

## Interface
- `CLK_HZ`, default 40_000_000: system clock frequency. Per-key half-period constants are derived from it.
- `TIMEOUT`, default 4000: number of `clk` cycles without an `sck` rising edge after which the frame bit counter resynchronises.
- `AMP`, default 19: contribution of each high voice to `wave`. 13*AMP must be ≤ 255.
- Clocking: one clock, `clk`. Reset is synchronous and active-low, on `reset_n`.
- `clk` input, 1 bit: system clock.
- `reset_n` input, 1 bit: synchronous, active-low reset.
- `sck` input, 1 bit: SPI clock from the master. Asynchronous to `clk`.
- `q` input, 32 bits: the shift-register contents from `spi_slave_receive_only`.
- `wave` output, 8 bits: mixed audio sample, unsigned.
- `frame_err` output, 1 bit: one-cycle pulse when a completed frame has a bad sync byte.

## Operation
- **Word format**
  - q[31:24] is the sync byte and must equal 8'hA5.
  - q[23:15] are ignored.
  - q[14:13] select the octave, `oct` = 0..3.
  - q[12:0] are the key bitmap: bit 0 = C4, bit 1 = C#4, … bit 9 = A4, … bit 12 = C5.
- **Frame detection**
  - `sck` passes through a 2-FF synchronizer, then a rising-edge detector.
  - A 5-bit bit counter increments on each detected edge. The 32nd edge completes the frame and the counter wraps to 0.
  - An idle counter clears on every detected edge. When it reaches TIMEOUT, the bit counter is forced to 0 (resynchronise) and the idle counter saturates.
- **Capture FSM**
  - States: IDLE → WAIT1 → WAIT2 → CHECK → IDLE.
  - The 32nd edge moves IDLE to WAIT1. The two wait states let `q` settle across domains.
  - In CHECK, `q` is sampled. If q[31:24]==8'hA5, `keys` ← q[12:0] and `oct` ← q[14:13]. Otherwise `frame_err` = 1 for that cycle and `keys`/`oct` are unchanged.
- **Voices (13)**
  - Each voice has a 17-bit counter `cnt` and a level bit `lvl`.
  - `lim` = HALF[k] >> `oct`, where HALF[k] = round(CLK_HZ / (2·f_k)).
  - f_k runs over 261.63, 277.18, 293.66, 311.13, 329.63, 349.23, 369.99, 392.00, 415.30, 440.00, 466.16, 493.88, 523.25 Hz.
  - At 40 MHz: A4 = 45455, C4 = 76445, C5 = 38223.
  - Key off: `cnt` = 0 and `lvl` = 0, held.
  - Key on: if `cnt` ≥ `lim` − 1, then `cnt` ← 0 and `lvl` toggles; otherwise `cnt` increments. The ≥ compare makes an octave raise wrap the voice immediately.
  - A key that stays on across frames is phase-continuous.
- **Mix**
  - `wave` is registered: `wave` ← AMP × (number of voices with `lvl` = 1).
  - The sum is at most 247, so there is no overflow or saturation.
- **Reset**
  - With `reset_n` = 0 at a `clk` edge: `wave` = 0, `frame_err` = 0, `keys` = 0, `oct` = 0, all `cnt`/`lvl` = 0.
  - The FSM goes to IDLE and the bit, idle and synchronizer registers clear.
  - Reset mid-frame discards the partial frame. `sck` edges seen during reset are not counted.

## Timing
- SPI constraints:
  - `sck` high and low phases are each ≥ 4 `clk` cycles.
  - Consecutive frames are separated by ≥ 8 `clk` cycles with `sck` low.
- The edge-detect pulse asserts 2–3 cycles after the `sck` rising edge at the pin.
- For the 32nd edge pulse in cycle N: CHECK occurs in cycle N+3, and `keys`/`frame_err` update at the end of N+3.
- A newly pressed voice counts from N+4. Its first `lvl` rise comes after `lim` cycles, and `wave` reflects it 1 cycle later.
- A key release zeroes `lvl` at the end of N+3, and `wave` drops 1 cycle later.
- `frame_err` is exactly one cycle wide, and there is at most one pulse per frame.

## Test plan
1. **Reset:** hold `reset_n` = 0 for 3 cycles while toggling `sck` → `wave` = 0 and `frame_err` = 0. Then send a valid frame → it is accepted, proving no edges were counted during reset.
2. **Single key:** frame 0xA5000200 → `wave` alternates 0/19, each phase 45455 cycles; the first rise is 45456 cycles after CHECK.
3. **Octave:** frame 0xA5002200 → A4 half-period is 22727 cycles. Then frame 0xA5006200 (`oct` = 3) mid-phase → a wrap occurs on the next cycle and the half-period becomes 5681.
4. **Chord:** frame 0xA5001FFF → first `wave` step to 19 after 38224 cycles (C5); `wave` stays ≤ 247 and reaches 247 only when all 13 levels are high.
5. **Bad sync:** frame 0x5A000200 → `frame_err` pulses for exactly 1 cycle and the previous tone continues unchanged. Then frame 0xA5000000 → `wave` = 0 within 5 cycles of the last edge.
6. **Resync:** send 20 `sck` edges, idle for 4001 cycles, then send a valid frame 0xA5000001 → the frame is accepted and C4 plays with half-period 76445.
